// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel ON/IDLE/OFF/WAKE state machine
// driving one ICG enable each, with idle auto-gating and a fixed wake settling delay.

module clk_gate_lane #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              busy,
    input  logic              auto_en,
    input  logic [IDLE_W-1:0] idle_thr,
    output logic              en_q,
    output logic              on_q,
    output logic              evt_q
);
    localparam int WK_W = (WAKE_DLY < 1) ? 1 : $clog2(WAKE_DLY + 1);
    localparam logic [WK_W-1:0] WAKE_LAST = WK_W'(WAKE_DLY - 1);

    typedef enum logic [1:0] {ST_ON, ST_IDLE, ST_OFF, ST_WAKE} state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WK_W-1:0]   wake_cnt;

    // Outputs are updated only on transitions that change them, so they always
    // reflect the state being entered on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ON;
            idle_cnt <= '0;
            wake_cnt <= '0;
            en_q     <= 1'b1;
            on_q     <= 1'b1;
            evt_q    <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            unique case (state)
                ST_ON: begin
                    if (!req) begin
                        state <= ST_OFF;
                        en_q  <= 1'b0;
                        on_q  <= 1'b0;
                        evt_q <= 1'b1;
                    end else if (auto_en && !busy && idle_thr != '0) begin
                        state    <= ST_IDLE;
                        idle_cnt <= '0;
                    end
                end
                ST_IDLE: begin
                    if (!req) begin
                        state <= ST_OFF;
                        en_q  <= 1'b0;
                        on_q  <= 1'b0;
                        evt_q <= 1'b1;
                    end else if (busy || !auto_en || idle_thr == '0) begin
                        state <= ST_ON;
                    end else if (idle_cnt >= idle_thr - IDLE_W'(1)) begin
                        // live compare: a lowered threshold gates at once
                        state <= ST_OFF;
                        en_q  <= 1'b0;
                        on_q  <= 1'b0;
                        evt_q <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_OFF: begin
                    if (req && (busy || !auto_en)) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                        en_q     <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (!req) begin
                        state <= ST_OFF;
                        en_q  <= 1'b0;
                        on_q  <= 1'b0;
                        evt_q <= 1'b1;
                    end else if (wake_cnt == WAKE_LAST) begin
                        state <= ST_ON;
                        on_q  <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + WK_W'(1);
                    end
                end
                default: begin
                    state <= ST_ON;
                    en_q  <= 1'b1;
                    on_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule

module clk_gate_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              glb_en,
    input  logic [NUM_CH-1:0] peri_en,
    input  logic [NUM_CH-1:0] local_en,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] auto_en,
    input  logic [IDLE_W-1:0] idle_thr,
    input  logic              test_mode,
    output logic [NUM_CH-1:0] clk_en_out,
    output logic [NUM_CH-1:0] ch_on,
    output logic [NUM_CH-1:0] gate_evt
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] en_q;

    assign req = {NUM_CH{glb_en}} & peri_en & local_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gate_lane #(
            .IDLE_W   (IDLE_W),
            .WAKE_DLY (WAKE_DLY)
        ) u_lane (
            .clk      (clk_in),
            .rst      (rst_in),
            .req      (req[i]),
            .busy     (busy[i]),
            .auto_en  (auto_en[i]),
            .idle_thr (idle_thr),
            .en_q     (en_q[i]),
            .on_q     (ch_on[i]),
            .evt_q    (gate_evt[i])
        );
    end

    // test_mode bypasses gating without disturbing the state machines
    assign clk_en_out = en_q | {NUM_CH{test_mode}};
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomized and directed bench for clk_gate_ctrl against a cycle-count reference model.

module tb_clk_gate_ctrl;
    localparam int NUM_CH   = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_DLY = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              glb_en;
    logic [NUM_CH-1:0] peri_en, local_en, busy, auto_en;
    logic [IDLE_W-1:0] idle_thr;
    logic              test_mode;
    logic [NUM_CH-1:0] clk_en_out, ch_on, gate_evt;

    clk_gate_ctrl #(.NUM_CH(NUM_CH), .IDLE_W(IDLE_W), .WAKE_DLY(WAKE_DLY)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .glb_en     (glb_en),
        .peri_en    (peri_en),
        .local_en   (local_en),
        .busy       (busy),
        .auto_en    (auto_en),
        .idle_thr   (idle_thr),
        .test_mode  (test_mode),
        .clk_en_out (clk_en_out),
        .ch_on      (ch_on),
        .gate_evt   (gate_evt)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: gated flag, cycles left until settled, cycles already idle (-1 = active)
    bit m_off  [NUM_CH];
    int m_wake [NUM_CH];
    int m_idle [NUM_CH];
    bit m_evt  [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            bit r;
            int thr;
            r   = glb_en & peri_en[i] & local_en[i];
            thr = int'(idle_thr);
            if (rst_in) begin
                m_off[i] = 0; m_wake[i] = 0; m_idle[i] = -1; m_evt[i] = 0;
            end else begin
                m_evt[i] = 0;
                if (m_off[i]) begin
                    if (r && (busy[i] || !auto_en[i])) begin
                        m_off[i] = 0; m_wake[i] = WAKE_DLY; m_idle[i] = -1;
                    end
                end else if (!r) begin
                    m_off[i] = 1; m_evt[i] = 1; m_wake[i] = 0; m_idle[i] = -1;
                end else if (m_wake[i] > 0) begin
                    m_wake[i]--;
                end else if (m_idle[i] < 0) begin
                    if (auto_en[i] && !busy[i] && thr != 0) m_idle[i] = 0;
                end else if (busy[i] || !auto_en[i] || thr == 0) begin
                    m_idle[i] = -1;
                end else if (m_idle[i] + 1 >= thr) begin
                    m_off[i] = 1; m_evt[i] = 1; m_idle[i] = -1;
                end else begin
                    m_idle[i]++;
                end
            end
        end
    endfunction

    task automatic tick();
        logic [NUM_CH-1:0] e_en, e_on, e_evt;
        @(posedge clk_in);
        model_step();
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            e_en[i]  = !m_off[i] | test_mode;
            e_on[i]  = !m_off[i] && m_wake[i] == 0;
            e_evt[i] = m_evt[i];
        end
        chk("model_clk_en", 32'(clk_en_out), 32'(e_en));
        chk("model_ch_on", 32'(ch_on), 32'(e_on));
        chk("model_gate_evt", 32'(gate_evt), 32'(e_evt));
    endtask

    task automatic all_on();
        glb_en = 1; peri_en = '1; local_en = '1; auto_en = '1; busy = '1; test_mode = 0;
    endtask

    initial begin
        logic [NUM_CH-1:0] evt_seen;

        // reset with random inputs
        rst_in = 1; glb_en = 1'($urandom); peri_en = NUM_CH'($urandom);
        local_en = NUM_CH'($urandom); busy = NUM_CH'($urandom); auto_en = NUM_CH'($urandom);
        idle_thr = IDLE_W'($urandom); test_mode = 0;
        tick();
        chk("rst_clk_en", 32'(clk_en_out), 32'hF);
        chk("rst_ch_on", 32'(ch_on), 32'hF);
        chk("rst_gate_evt", 32'(gate_evt), 32'h0);
        tick();
        rst_in = 0;
        all_on(); idle_thr = 3;
        repeat (3) tick();

        // auto-gate channel 0 after 3 idle cycles
        busy[0] = 0;
        repeat (3) tick();
        chk("ag_en_before", 32'(clk_en_out), 32'hF);
        chk("ag_evt_before", 32'(gate_evt), 32'h0);
        tick();
        chk("ag_en_gated", 32'(clk_en_out), 32'hE);
        chk("ag_evt", 32'(gate_evt), 32'h1);
        chk("ag_on_others", 32'(ch_on), 32'hE);
        tick();
        chk("ag_evt_once", 32'(gate_evt), 32'h0);

        // busy blip on channel 1 restarts the idle count
        busy[1] = 0; tick(); tick();
        busy[1] = 1; tick();
        busy[1] = 0; repeat (3) tick();
        chk("blip_still_on", 32'(ch_on[1]), 32'h1);
        tick();
        chk("blip_gated", 32'(gate_evt[1]), 32'h1);
        chk("blip_en", 32'(clk_en_out[1]), 32'h0);

        // wake channel 0
        busy[0] = 1; tick();
        chk("wake_en", 32'(clk_en_out[0]), 32'h1);
        chk("wake_on_early", 32'(ch_on[0]), 32'h0);
        tick();
        chk("wake_on_mid", 32'(ch_on[0]), 32'h0);
        tick();
        chk("wake_on", 32'(ch_on[0]), 32'h1);

        // regate ch0, then lose local_en during WAKE
        busy[0] = 0; repeat (4) tick();
        chk("regate", 32'(clk_en_out[0]), 32'h0);
        busy[0] = 1; tick();
        local_en[0] = 0; tick();
        chk("wake_abort_evt", 32'(gate_evt[0]), 32'h1);
        chk("wake_abort_en", 32'(clk_en_out[0]), 32'h0);
        local_en[0] = 1; busy = '1; repeat (4) tick();
        chk("all_back_on", 32'(ch_on), 32'hF);

        // forced gate under test_mode
        test_mode = 1; glb_en = 0; tick();
        chk("tm_ch_on", 32'(ch_on), 32'h0);
        chk("tm_evt", 32'(gate_evt), 32'hF);
        chk("tm_clk_en", 32'(clk_en_out), 32'hF);
        test_mode = 0; glb_en = 1; repeat (4) tick();

        // idle_thr=0 disables auto-gating
        idle_thr = 0; busy = '0; evt_seen = '0;
        repeat (300) begin
            tick();
            evt_seen |= gate_evt;
        end
        chk("thr0_no_evt", 32'(evt_seen), 32'h0);
        chk("thr0_on", 32'(ch_on), 32'hF);

        // random phase
        repeat (2000) begin
            rst_in    = ($urandom_range(0, 199) == 0);
            glb_en    = ($urandom_range(0, 19) != 0);
            test_mode = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                peri_en[i]  = ($urandom_range(0, 29) != 0);
                local_en[i] = ($urandom_range(0, 19) != 0);
                busy[i]     = ($urandom_range(0, 3) == 0);
                auto_en[i]  = ($urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 15) == 0) idle_thr = IDLE_W'($urandom_range(0, 6));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
